// File: rtl/wb_commit_unit.sv
// Registered writeback commit stage: turns one bundle per cycle into one-cycle register write
// strobes, and merges user-mode privileged-write faults with external interrupts into a held request.
//
// irq state | meaning
// ----------+------------------------------------------------------------
// IRQ_IDLE  | no request presented, irq_valid_o low
// IRQ_EXT   | presenting an external interrupt; its ack leaves fault_cnt alone
// IRQ_FAULT | presenting a queued fault; its ack pops one entry from fault_cnt
module wb_commit_unit #(
   parameter int DATA_W     = 32,
   parameter int CH_W       = 4,
   parameter int NUM_REGS   = 15,
   parameter int FLAG_IDX   = 9,
   parameter int SP_IDX     = 13,
   parameter int PRIV_IDX   = 14,
   parameter int FAULT_NUM  = 8,
   parameter int PEND_DEPTH = 4,
   localparam int CNT_W     = $clog2(PEND_DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [CH_W-1:0]     y1_channel_i,
   input  logic [1:0]          y2_channel_i,
   input  logic [DATA_W-1:0]   y1_data_i,
   input  logic [DATA_W-1:0]   y2_data_i,
   input  logic                user_mode_i,
   input  logic                flush_i,
   output logic [NUM_REGS-1:0] reg_we_o,
   output logic [DATA_W-1:0]   reg_wdata_o,
   output logic [DATA_W-1:0]   flag_wdata_o,
   output logic [DATA_W-1:0]   sp_wdata_o,
   input  logic                ext_irq_i,
   input  logic [7:0]          ext_irq_num_i,
   output logic                irq_valid_o,
   output logic [7:0]          irq_num_o,
   input  logic                irq_ack_i,
   output logic [CNT_W-1:0]    fault_cnt_o
);

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_EXT,
      IRQ_FAULT
   } irq_state_t;

   irq_state_t          irq_state_q, irq_state_d;
   logic [7:0]          irq_num_q, irq_num_d;
   logic [CNT_W-1:0]    fault_cnt_q, fault_cnt_d;
   logic [NUM_REGS-1:0] reg_we_q, reg_we_d;
   logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
   logic [DATA_W-1:0]   flag_wdata_q, flag_wdata_d;
   logic [DATA_W-1:0]   sp_wdata_q, sp_wdata_d;

   logic [31:0] y1_idx;
   logic        commit;
   logic        priv_fault;
   logic        y1_write;
   logic        fault_dec;
   logic        fault_avail;
   logic        irq_load;

   assign in_ready_o = (fault_cnt_q < CNT_W'(PEND_DEPTH));
   assign y1_idx     = 32'(y1_channel_i);
   assign commit     = in_valid_i && in_ready_o && !flush_i;
   assign priv_fault = commit && user_mode_i && (y1_idx == 32'(PRIV_IDX));
   assign y1_write   = commit && !priv_fault && (y1_idx != 32'd0)
                       && (y1_idx < 32'(NUM_REGS));

   always_comb begin
      reg_we_d     = '0;
      reg_wdata_d  = reg_wdata_q;
      flag_wdata_d = flag_wdata_q;
      sp_wdata_d   = sp_wdata_q;

      if (y1_write) begin
         reg_wdata_d = y1_data_i;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (y1_idx == 32'(r)) begin
               reg_we_d[r] = 1'b1;
            end
         end
         if (y1_idx == 32'(FLAG_IDX)) begin
            flag_wdata_d = y1_data_i;
         end
         if (y1_idx == 32'(SP_IDX)) begin
            sp_wdata_d = y1_data_i;
         end
      end

      // y2 is applied after y1 so it wins when both target FLAG or SP
      if (commit && (y2_channel_i == 2'd1)) begin
         reg_we_d[FLAG_IDX] = 1'b1;
         flag_wdata_d       = y2_data_i;
      end
      if (commit && (y2_channel_i == 2'd2)) begin
         reg_we_d[SP_IDX] = 1'b1;
         sp_wdata_d       = y2_data_i;
      end
   end

   // A fault being popped this cycle must not be re-presented, and a fault
   // pushed this cycle only becomes visible once it is in fault_cnt_q.
   assign fault_dec   = (irq_state_q == IRQ_FAULT) && irq_ack_i;
   assign fault_avail = (fault_cnt_q > CNT_W'(fault_dec));
   assign irq_load    = (irq_state_q == IRQ_IDLE) || irq_ack_i;

   always_comb begin
      irq_state_d = irq_state_q;
      irq_num_d   = irq_num_q;
      if (irq_load) begin
         if (ext_irq_i) begin
            irq_state_d = IRQ_EXT;
            irq_num_d   = ext_irq_num_i;
         end else if (fault_avail) begin
            irq_state_d = IRQ_FAULT;
            irq_num_d   = 8'(FAULT_NUM);
         end else begin
            irq_state_d = IRQ_IDLE;
         end
      end
   end

   always_comb begin
      fault_cnt_d = fault_cnt_q;
      if (priv_fault && !fault_dec) begin
         fault_cnt_d = fault_cnt_q + CNT_W'(1);
      end else if (!priv_fault && fault_dec) begin
         fault_cnt_d = fault_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_state_q  <= IRQ_IDLE;
         irq_num_q    <= '0;
         fault_cnt_q  <= '0;
         reg_we_q     <= '0;
         reg_wdata_q  <= '0;
         flag_wdata_q <= '0;
         sp_wdata_q   <= '0;
      end else begin
         irq_state_q  <= irq_state_d;
         irq_num_q    <= irq_num_d;
         fault_cnt_q  <= fault_cnt_d;
         reg_we_q     <= reg_we_d;
         reg_wdata_q  <= reg_wdata_d;
         flag_wdata_q <= flag_wdata_d;
         sp_wdata_q   <= sp_wdata_d;
      end
   end

   assign reg_we_o     = reg_we_q;
   assign reg_wdata_o  = reg_wdata_q;
   assign flag_wdata_o = flag_wdata_q;
   assign sp_wdata_o   = sp_wdata_q;
   assign irq_valid_o  = (irq_state_q != IRQ_IDLE);
   assign irq_num_o    = irq_num_q;
   assign fault_cnt_o  = fault_cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios followed by random bundles, all checked
// every cycle against a queue-count reference model.
module tb_wb_commit_unit;

   localparam int DATA_W = 32;
   localparam int CH_W   = 4;
   localparam int NREG   = 15;
   localparam int DEPTH  = 4;
   localparam int FNUM   = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [CH_W-1:0]   y1_channel;
   logic [1:0]        y2_channel;
   logic [DATA_W-1:0] y1_data, y2_data;
   logic              user_mode, flush;
   logic [NREG-1:0]   reg_we;
   logic [DATA_W-1:0] reg_wdata, flag_wdata, sp_wdata;
   logic              ext_irq;
   logic [7:0]        ext_irq_num;
   logic              irq_valid;
   logic [7:0]        irq_num;
   logic              irq_ack;
   logic [2:0]        fault_cnt;

   always #5 clk = ~clk;

   wb_commit_unit dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .y1_channel_i(y1_channel), .y2_channel_i(y2_channel),
      .y1_data_i(y1_data), .y2_data_i(y2_data),
      .user_mode_i(user_mode), .flush_i(flush),
      .reg_we_o(reg_we), .reg_wdata_o(reg_wdata),
      .flag_wdata_o(flag_wdata), .sp_wdata_o(sp_wdata),
      .ext_irq_i(ext_irq), .ext_irq_num_i(ext_irq_num),
      .irq_valid_o(irq_valid), .irq_num_o(irq_num),
      .irq_ack_i(irq_ack), .fault_cnt_o(fault_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference model: pending faults kept as a plain count, the presented
   // request remembered as (valid, number, came-from-fault)
   int         m_pending;
   bit [14:0]  m_we;
   bit [31:0]  m_reg, m_flag, m_sp;
   bit         m_irq_v, m_irq_fault;
   bit [7:0]   m_irq_num;

   task automatic model_reset();
      m_pending = 0; m_we = '0; m_reg = '0; m_flag = '0; m_sp = '0;
      m_irq_v = 0; m_irq_fault = 0; m_irq_num = '0;
   endtask

   task automatic model_step();
      int  ch;
      bit  take, fault, popped;
      int  seen;
      take   = in_valid && (m_pending < DEPTH) && !flush;
      ch     = int'(y1_channel);
      fault  = take && user_mode && (ch == 14);
      m_we   = '0;
      if (take) begin
         if (!fault && ch >= 1 && ch < NREG) begin
            m_we  = m_we | (15'd1 << ch);
            m_reg = y1_data;
            if (ch == 9)  m_flag = y1_data;
            if (ch == 13) m_sp   = y1_data;
         end
         if (y2_channel == 2'd1) begin m_we[9]  = 1'b1; m_flag = y2_data; end
         if (y2_channel == 2'd2) begin m_we[13] = 1'b1; m_sp   = y2_data; end
      end
      popped = m_irq_v && irq_ack && m_irq_fault;
      seen   = m_pending - (popped ? 1 : 0);
      if (!m_irq_v || irq_ack) begin
         if (ext_irq) begin
            m_irq_v = 1; m_irq_num = ext_irq_num; m_irq_fault = 0;
         end else if (seen > 0) begin
            m_irq_v = 1; m_irq_num = 8'(FNUM); m_irq_fault = 1;
         end else begin
            m_irq_v = 0;
         end
      end
      m_pending = seen + (fault ? 1 : 0);
   endtask

   task automatic check_all();
      chk("reg_we", 32'(reg_we), 32'(m_we));
      chk("reg_wdata", reg_wdata, m_reg);
      chk("flag_wdata", flag_wdata, m_flag);
      chk("sp_wdata", sp_wdata, m_sp);
      chk("irq_valid", 32'(irq_valid), 32'(m_irq_v));
      if (m_irq_v) chk("irq_num", 32'(irq_num), 32'(m_irq_num));
      chk("fault_cnt", 32'(fault_cnt), 32'(m_pending));
   endtask

   task automatic cycle();
      chk("in_ready", 32'(in_ready), 32'(m_pending < DEPTH));
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic bundle(input bit v, input int ch, input int y2, input bit [31:0] d1,
                         input bit [31:0] d2, input bit um, input bit fl);
      in_valid = v; y1_channel = 4'(ch); y2_channel = 2'(y2);
      y1_data = d1; y2_data = d2; user_mode = um; flush = fl;
   endtask

   initial begin
      rst_n = 1'b0;
      bundle(0, 0, 0, 0, 0, 0, 0);
      ext_irq = 0; ext_irq_num = '0; irq_ack = 0;
      model_reset();
      #2;
      chk("rst_we", 32'(reg_we), 0);
      chk("rst_irq_valid", 32'(irq_valid), 0);
      chk("rst_fault_cnt", 32'(fault_cnt), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      #10 rst_n = 1'b1;

      // plain y1 write, strobe lasts one cycle
      bundle(1, 3, 0, 32'hDEADBEEF, 0, 0, 0);
      cycle();
      chk("t1_we", 32'(reg_we), 32'h0008);
      chk("t1_wdata", reg_wdata, 32'hDEADBEEF);
      in_valid = 0;
      cycle();
      chk("t1_we_clear", 32'(reg_we), 0);

      // y2 overrides y1 on FLAG; then y1 FLAG plus y2 SP
      bundle(1, 9, 1, 32'h1, 32'h5, 0, 0);
      cycle();
      chk("t2_we", 32'(reg_we), 32'h0200);
      chk("t2_flag", flag_wdata, 32'h5);
      bundle(1, 9, 2, 32'h1, 32'h100, 0, 0);
      cycle();
      chk("t2b_we", 32'(reg_we), 32'h2200);
      chk("t2b_flag", flag_wdata, 32'h1);
      chk("t2b_sp", sp_wdata, 32'h100);
      in_valid = 0;
      cycle();

      // user-mode privileged write becomes a fault
      bundle(1, 14, 0, 32'hAA, 0, 1, 0);
      cycle();
      chk("t3_we", 32'(reg_we), 0);
      chk("t3_cnt", 32'(fault_cnt), 1);
      in_valid = 0;
      cycle();
      cycle();
      chk("t3_irq_valid", 32'(irq_valid), 1);
      chk("t3_irq_num", 32'(irq_num), 8);
      irq_ack = 1;
      cycle();
      irq_ack = 0;
      chk("t3_cnt_pop", 32'(fault_cnt), 0);
      chk("t3_irq_idle", 32'(irq_valid), 0);
      bundle(1, 14, 0, 32'hAB, 0, 0, 0);
      cycle();
      chk("t3_priv_we", 32'(reg_we), 32'h4000);
      in_valid = 0;

      // fill the fault queue, fifth bundle stalls until one ack
      bundle(1, 14, 0, 32'h77, 0, 1, 0);
      repeat (5) cycle();
      chk("t4_cnt_full", 32'(fault_cnt), 4);
      chk("t4_ready_low", 32'(in_ready), 0);
      irq_ack = 1;
      cycle();
      irq_ack = 0;
      chk("t4_ready_back", 32'(in_ready), 1);
      cycle();
      chk("t4_cnt_refill", 32'(fault_cnt), 4);
      in_valid = 0;
      irq_ack = 1;
      repeat (6) cycle();
      irq_ack = 0;
      chk("t4_drained", 32'(fault_cnt), 0);

      // external interrupt beats a queued fault
      bundle(1, 14, 0, 32'h1, 0, 1, 0);
      cycle();
      in_valid = 0;
      ext_irq = 1; ext_irq_num = 8'h21;
      cycle();
      chk("t5_ext_num", 32'(irq_num), 32'h21);
      ext_irq = 0;
      irq_ack = 1;
      cycle();
      chk("t5_fault_num", 32'(irq_num), 8);
      cycle();
      irq_ack = 0;
      chk("t5_idle", 32'(irq_valid), 0);

      // flush drops the bundle
      bundle(1, 2, 0, 32'h1234, 0, 0, 1);
      cycle();
      chk("t6_flush_we", 32'(reg_we), 0);
      bundle(0, 0, 0, 0, 0, 0, 0);

      // async reset while a request is held
      ext_irq = 1; ext_irq_num = 8'h55;
      bundle(1, 5, 2, 32'hCAFE, 32'hF00D, 0, 0);
      cycle();
      bundle(0, 0, 0, 0, 0, 0, 0);
      ext_irq = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_irq_valid", 32'(irq_valid), 0);
      chk("rst_mid_irq_num", 32'(irq_num), 0);
      chk("rst_mid_we", 32'(reg_we), 0);
      chk("rst_mid_wdata", reg_wdata, 0);
      chk("rst_mid_sp", sp_wdata, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic
      repeat (600) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         y1_channel  = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
         y2_channel  = 2'($urandom_range(0, 3));
         y1_data     = $urandom;
         y2_data     = $urandom;
         user_mode   = $urandom_range(0, 1) == 1;
         flush       = ($urandom_range(0, 7) == 0);
         ext_irq     = ($urandom_range(0, 5) == 0);
         ext_irq_num = ($urandom_range(0, 3) == 0) ? 8'd8 : 8'($urandom_range(0, 255));
         irq_ack     = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
Parametrised, registered successor to the combinational writeback decoder. It accepts one writeback bundle per cycle: a y1 channel index plus data, and an optional y2 direct write to FLAG or SP. It produces one-cycle-late per-register write strobes. Privileged-register writes in user mode become queued faults, which are merged with external interrupts into a held valid/ack interrupt request. Sits between execute and the register file/interrupt controller.

Parameters:
DATA_W, 32, register data width
CH_W, 4, y1 channel index width
NUM_REGS, 15, strobe vector width; index 0 = no write
FLAG_IDX, 9, index of FLAG register
SP_IDX, 13, index of SP register
PRIV_IDX, 14, privileged register index (TLB)
FAULT_NUM, 8, interrupt number raised for a user-mode privileged write
PEND_DEPTH, 4, max queued faults (counter saturates here)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  writeback bundle valid
in_ready  out  1  bundle accepted when in_valid && in_ready
y1_channel  in  CH_W  y1 destination index
y2_channel  in  2  0 none, 1 FLAG, 2 SP, 3 reserved (ignored)
y1_data  in  DATA_W  y1 write data
y2_data  in  DATA_W  y2 write data
user_mode  in  1  1 = unprivileged; sampled with the bundle
flush  in  1  discard bundle accepted this cycle
reg_we  out  NUM_REGS  one-cycle write strobes, bit i = register i
reg_wdata  out  DATA_W  data for every strobe except FLAG/SP
flag_wdata  out  DATA_W  FLAG write data
sp_wdata  out  DATA_W  SP write data
ext_irq  in  1  external interrupt request (level)
ext_irq_num  in  8  external interrupt number
irq_valid  out  1  interrupt request to controller
irq_num  out  8  number of presented interrupt
irq_ack  in  1  controller consumed irq_valid
fault_cnt  out  clog2(PEND_DEPTH+1)  queued faults (debug/verification)

Behaviour:
- Reset (rst_n low, async): reg_we=0, all data outputs 0, irq_valid=0, irq_num=0, fault_cnt=0. in_ready=1 once fault_cnt<PEND_DEPTH.
- in_ready = (fault_cnt < PEND_DEPTH). This is combinational from the counter only.
- Accept cycle T, no flush: outputs at T+1 are registered and last exactly one cycle.
  - Let i = y1_channel. If 1 <= i < NUM_REGS, then reg_we[i]=1 with reg_wdata=y1_data. Index 0 or i >= NUM_REGS: no y1 write.
  - If i==FLAG_IDX, flag_wdata=y1_data. If i==SP_IDX, sp_wdata=y1_data.
  - y2_channel=1: reg_we[FLAG_IDX]=1, flag_wdata=y2_data. If y1 also targets FLAG, y2 wins.
  - y2_channel=2: same rule for SP.
  - i==PRIV_IDX with user_mode=1: no strobe. Instead fault_cnt increments at T+1.
  - i==PRIV_IDX with user_mode=0: normal write.
- No accept, or flush=1 at T: reg_we=0 at T+1 and no fault is queued. Data outputs hold their last values.
- Interrupt output register:
  - Loads when irq_valid==0, or when irq_valid && irq_ack.
  - Load priority: ext_irq=1 gives irq_num=ext_irq_num. Otherwise fault_cnt>0 gives irq_num=FAULT_NUM. Otherwise irq_valid=0.
  - A new fault enqueued this cycle is not visible to the load until the next cycle.
  - While irq_valid && !irq_ack, irq_valid and irq_num hold stable regardless of ext_irq.
- fault_cnt:
  - Decrements when a presented FAULT-sourced request is acked.
  - Simultaneous increment and decrement leaves it unchanged.
  - It never exceeds PEND_DEPTH, because in_ready=0 at full.
  - Track each presented request's source with one state bit (ext vs fault). Do not compare irq_num, since ext_irq_num may equal FAULT_NUM.
- Back-to-back accepts every cycle are supported: full throughput while not full.
- flush does not affect the interrupt path or fault_cnt.

Test Plan:
- Accept y1_channel=3, y1_data=0xDEADBEEF, y2=0 -> next cycle reg_we=0x0008, reg_wdata=0xDEADBEEF. Following cycle reg_we=0.
- Accept y1_channel=9, y1_data=1, y2_channel=1, y2_data=0x5 -> reg_we bit9 only, flag_wdata=0x5. Repeat with y2_channel=2 and y2_data=0x100 -> bits 9 and 13 set, flag_wdata=1, sp_wdata=0x100.
- user_mode=1, y1_channel=14, with irq_ack held low -> no strobe, fault_cnt=1, then irq_valid=1 with irq_num=8 held. Pulse irq_ack -> fault_cnt=0, irq_valid=0. Same bundle with user_mode=0 -> reg_we bit14.
- Five privileged user-mode bundles with irq_ack=0 -> fault_cnt reaches 4, in_ready=0, fifth bundle held. One ack -> in_ready=1, fifth accepted, fault_cnt=4.
- ext_irq=1 with ext_irq_num=0x21, raised while one fault is queued and irq_valid=0 -> irq_num=0x21 first. After ack, irq_num=8. After second ack, irq_valid=0.
- flush asserted with an accepted y1_channel=2 bundle -> reg_we stays 0. Assert rst_n=0 mid-irq_valid -> all outputs 0 immediately.
